// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states and the
// buffered fetch entry.
package fetch_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO holding fetched words until decode takes them.
// Flush empties it in one cycle; the head is read straight from storage.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic [CW-1:0] count,
    output logic         valid,
    output fetch_entry_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid = (count != '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues word reads, tags returned words with
// their PC, and hands them to decode through a small credit-managed buffer.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_BYTES = 256,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fault
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES) - INSTR_BYTES;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          pop, push, credit_ok, pc_legal, redir_legal, attempt, issue;
    fetch_entry_t  head;

    assign imem_addr = fetch_pc;
    assign pop       = inst_valid & inst_ready;
    // A word in flight already owns a slot, so it counts against credit.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign credit_ok = occupancy < (CW+1)'(DEPTH);

    assign pc_legal    = (fetch_pc[1:0] == 2'b00) && (fetch_pc <= LAST_PC);
    assign redir_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_PC);
    assign attempt     = (state == RUN) && fetch_en && credit_ok && !redirect_valid;
    assign issue       = attempt && pc_legal;
    assign push        = inflight && !redirect_valid;

    fetch_buffer #(.DEPTH(DEPTH), .CW(CW)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry ('{pc: inflight_pc, data: imem_data}),
        .pop        (pop),
        .count      (count),
        .valid      (inst_valid),
        .head       (head)
    );

    assign inst_data = head.data;
    assign inst_pc   = head.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fault       <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + INSTR_BYTES;
            end
            if (redirect_valid) fetch_pc <= redirect_pc;

            case (state)
                IDLE: if (fetch_en) state <= RUN;
                RUN: begin
                    if (!fetch_en) begin
                        state <= IDLE;
                    end else if (attempt && !pc_legal) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end
                end
                FAULT: begin
                    if (redirect_valid && redir_legal) begin
                        state <= fetch_en ? RUN : IDLE;
                        fault <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: the model holds the list of PCs decode must see after
// each restart point; a monitor pops it on every accepted instruction.
module tb_fetch_sequencer;

    localparam int MEM_BYTES = 256;
    localparam logic [31:0] LAST = 32'(MEM_BYTES - 4);

    logic        clk = 1'b0;
    logic        rst, fetch_en, redirect_valid, inst_ready;
    logic [31:0] redirect_pc, imem_addr, imem_data, inst_data, inst_pc;
    logic        inst_valid, fault;

    int vectors = 0;
    int errs    = 0;

    logic [7:0]  mem_b [MEM_BYTES];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fault          (fault)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int i;
        if (a > LAST) return 32'hDEAD_BEEF;
        i = int'(a);
        return {mem_b[i], mem_b[i+1], mem_b[i+2], mem_b[i+3]};
    endfunction

    // Big-endian memory with one-cycle registered read.
    always @(posedge clk) imem_data <= word_at(imem_addr);

    // Decode must see every word from the restart point to the end of memory.
    task automatic load_stream(input logic [31:0] start);
        exp_q.delete();
        if (start[1:0] == 2'b00 && start <= LAST)
            for (logic [31:0] p = start; p <= LAST; p += 4) exp_q.push_back(p);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        load_stream(pc);
        check("redirect_addr", imem_addr, pc);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!inst_valid && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (!inst_valid) begin
            errs++;
            $display("FAIL wait_valid: got inst_valid=0 expected 1 within %0d cycles", budget);
        end
    endtask

    // Monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL unexpected: got pc %h expected no instruction", inst_pc);
            end else begin
                logic [31:0] p;
                p = exp_q.pop_front();
                check("mon_pc", inst_pc, p);
                check("mon_data", inst_data, word_at(p));
            end
        end
    end

    initial begin
        logic [31:0] a, p;
        for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = 8'($urandom);
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; inst_ready = 1'b0;
        tick(2);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_data", inst_data, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        rst = 1'b0;
        tick(3);
        check("idle_no_issue", {31'd0, inst_valid}, 32'd0);

        // Start-up latency and back-to-back delivery.
        load_stream(32'h0);
        inst_ready = 1'b1;
        fetch_en   = 1'b1;
        tick(2);
        check("lat_early", {31'd0, inst_valid}, 32'd0);
        tick();
        check("lat_valid", {31'd0, inst_valid}, 32'd1);
        check("seq_pc0", inst_pc, 32'h0);
        tick(); check("seq_pc1", inst_pc, 32'h4);
        tick(); check("seq_pc2", inst_pc, 32'h8);
        tick(); check("seq_pc3", inst_pc, 32'hC);

        // Stall: address and head freeze, no word is lost on resume.
        inst_ready = 1'b0;
        tick(2);
        a = imem_addr; p = inst_pc;
        tick(4);
        check("stall_addr", imem_addr, a);
        check("stall_pc", inst_pc, p);
        check("stall_valid", {31'd0, inst_valid}, 32'd1);
        inst_ready = 1'b1;
        tick(4);

        // Redirect with a full buffer and a word in flight.
        inst_ready = 1'b0;
        tick(3);
        do_redirect(32'h40);
        inst_ready = 1'b1;
        wait_valid(6);
        check("redir_pc", inst_pc, 32'h40);
        tick(); check("redir_pc2", inst_pc, 32'h44);

        // Misaligned target faults; a legal one recovers.
        do_redirect(32'h42);
        tick(3);
        check("mis_fault", {31'd0, fault}, 32'd1);
        check("mis_valid", {31'd0, inst_valid}, 32'd0);
        do_redirect(32'h80);
        check("recover_fault", {31'd0, fault}, 32'd0);
        wait_valid(6);
        check("recover_pc", inst_pc, 32'h80);

        // End of memory: last two words delivered, then fault, no wrap.
        do_redirect(32'hF8);
        wait_valid(6);
        check("end_pc0", inst_pc, 32'hF8);
        tick(); check("end_pc1", inst_pc, 32'hFC);
        tick(6);
        check("end_fault", {31'd0, fault}, 32'd1);
        check("end_valid", {31'd0, inst_valid}, 32'd0);
        check("end_drained", 32'(exp_q.size()), 32'd0);

        // Randomized traffic with random stalls and redirects.
        do_redirect(32'h10);
        for (int c = 0; c < 600; c++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 5))
                    0:       p = 32'($urandom_range(0, 63) * 4 + 2);
                    1:       p = 32'h100 + 32'($urandom_range(0, 15) * 4);
                    default: p = 32'($urandom_range(0, 63) * 4);
                endcase
                do_redirect(p);
            end else begin
                tick();
            end
        end

        // Reset mid-stream with a full buffer.
        do_redirect(32'h20);
        inst_ready = 1'b0;
        tick(6);
        check("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
        rst = 1'b1;
        tick();
        load_stream(32'h0);
        check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_fault", {31'd0, fault}, 32'd0);
        rst = 1'b0;
        inst_ready = 1'b1;
        wait_valid(8);
        check("post_rst_pc", inst_pc, 32'h0);
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
